window_frame_reader: RTL and testbench

//  Reader side of the window sample stream. Accepts 12-bit samples from the window filter output
//  (one per din_valid), buffers them in a circular store, and hands them downstream in fixed-length

---
 rtl/window_frame_reader.sv | 183 ++++++++++++++++++
 tb/tb_window_frame_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_frame_reader.sv
// Circular sample buffer that emits fixed-length frames over a valid/ready stream.
// Optional FRAME_READER_PEAK_EN adds a per-frame peak detector (frame_peak/peak_valid).
module window_frame_reader #(
  parameter  int DATA_W    = 12,
  parameter  int FRAME_LEN = 16,
  parameter  int DEPTH     = 64,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
`ifdef FRAME_READER_PEAK_EN
  output logic [DATA_W-1:0] frame_peak,
  output logic              peak_valid,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [ADDR_W:0]  LVL_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  LVL_FRAME = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_cnt;
  state_t            r_state;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_last;

  logic              w_wr_en;
  logic              w_drop;
  logic              w_pop;
  logic [ADDR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_next;

  // Handshake: a beat transfers on any edge where rd_valid && rd_ready; while
  // rd_valid is high and rd_ready is low, rd_data/rd_valid/rd_last do not change.
  assign w_wr_en      = din_valid && (r_level != LVL_FULL);
  assign w_drop       = din_valid && (r_level == LVL_FULL);
  assign w_pop        = r_rd_valid && rd_ready;
  assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
  assign w_cnt_nxt    = r_cnt + 1'b1;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_next       = r_mem[w_rd_ptr_nxt];

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

  // Storage needs no reset: only entries counted by level are ever read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
          if (r_level >= LVL_FRAME) begin
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_rd_data  <= w_head;
          r_rd_valid <= 1'b1;
          r_rd_last  <= 1'b0;
          r_state    <= S_BURST;
        end
        S_BURST: begin
          // Whole frame is already buffered, so the word after the head is always valid.
          if (w_pop) begin
            if (r_cnt != CNT_LAST) begin
              r_cnt     <= w_cnt_nxt;
              r_rd_data <= w_next;
              r_rd_last <= (w_cnt_nxt == CNT_LAST);
            end else begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_READER_PEAK_EN
  logic [DATA_W-1:0] r_run_max;
  logic [DATA_W-1:0] r_frame_peak;
  logic              r_peak_valid;
  logic [DATA_W-1:0] w_beat_max;

  assign w_beat_max = (r_rd_data > r_run_max) ? r_rd_data : r_run_max;
  assign frame_peak = r_frame_peak;
  assign peak_valid = r_peak_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_max    <= '0;
      r_frame_peak <= '0;
      r_peak_valid <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      if (w_pop) begin
        if (r_rd_last) begin
          r_frame_peak <= w_beat_max;
          r_peak_valid <= 1'b1;
          r_run_max    <= '0;
        end else begin
          r_run_max <= w_beat_max;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_frame_reader.sv
// Directed bench for window_frame_reader (FRAME_LEN=4, DEPTH=8) with an expected-data queue.
module tb_window_frame_reader;

  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 4;
  localparam int DEPTH     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic [3:0]        level;
  logic              overflow;
  logic [1:0]        dbg_state;
`ifdef FRAME_READER_PEAK_EN
  logic [DATA_W-1:0] frame_peak;
  logic              peak_valid;
  logic [DATA_W-1:0] m_run;
  logic [DATA_W-1:0] m_peak;
`endif

  logic [DATA_W-1:0] exp_q[$];
  int                m_level;
  int                m_beat;
  bit                m_ovf;
  int                n_total;
  int                n_bad;

  window_frame_reader #(
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .level     (level),
    .overflow  (overflow),
`ifdef FRAME_READER_PEAK_EN
    .frame_peak(frame_peak),
    .peak_valid(peak_valid),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_level = 0;
    m_beat  = 0;
    m_ovf   = 1'b0;
`ifdef FRAME_READER_PEAK_EN
    m_run  = '0;
    m_peak = '0;
`endif
  endtask

  // One clock: evaluate handshake at the negedge, advance to the next negedge, check state.
  task automatic step();
    bit                full;
    bit                last_pop;
    logic [DATA_W-1:0] e;
    full     = (m_level == DEPTH);
    last_pop = 1'b0;
    e        = '0;
    if (din_valid && !full) begin
      exp_q.push_back(din);
      m_level++;
    end
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_with_empty_model", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
      end
      check("rd_last", rd_last, (m_beat == FRAME_LEN - 1));
`ifdef FRAME_READER_PEAK_EN
      if (m_beat == FRAME_LEN - 1) begin
        m_peak   = (e > m_run) ? e : m_run;
        m_run    = '0;
        last_pop = 1'b1;
      end else begin
        m_run = (e > m_run) ? e : m_run;
      end
`endif
      m_beat = (m_beat == FRAME_LEN - 1) ? 0 : m_beat + 1;
      m_level--;
    end
    if (din_valid && full) m_ovf = 1'b1;
    else if (clr_ovf)      m_ovf = 1'b0;
    @(negedge clk);
    check("level", level, m_level);
    check("overflow", overflow, m_ovf);
`ifdef FRAME_READER_PEAK_EN
    check("peak_valid", peak_valid, last_pop);
    check("frame_peak", frame_peak, m_peak);
`else
    if (last_pop) check("last_pop_flag", last_pop, 0);
`endif
  endtask

  // driver tasks
  task automatic write_sample(input logic [DATA_W-1:0] v);
    din       = v;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_reset();
    #3 reset = 1'b1;
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic drain(input int budget);
    rd_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() >= FRAME_LEN; i++) step();
    idle(3);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    clr_ovf   = 1'b0;
    rd_ready  = 1'b0;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    check("por_rd_valid", rd_valid, 0);
    check("por_level", level, 0);
    check("por_state", dbg_state, 0);
    reset = 1'b0;

    // T1: reset while a frame is presented
    for (int v = 1; v <= 4; v++) write_sample(12'(v));
    idle(2);
    check("t1_pre_valid", rd_valid, 1);
    check("t1_pre_data", rd_data, 1);
    apply_reset();

    // T2: frame appears two edges after the 4th write
    write_sample(12'd1);
    write_sample(12'd2);
    write_sample(12'd3);
    idle(1);
    check("t2_valid_lvl3", rd_valid, 0);
    write_sample(12'd4);
    check("t2_valid_e0", rd_valid, 0);
    idle(1);
    check("t2_valid_e1", rd_valid, 0);
    idle(1);
    check("t2_valid_e2", rd_valid, 1);
    check("t2_first", rd_data, 1);
    rd_ready = 1'b1;
    idle(4);
    check("t2_done_valid", rd_valid, 0);
    check("t2_q_empty", exp_q.size(), 0);
    rd_ready = 1'b0;

    // T3: backpressure holds the head beat, release streams without gaps
    for (int v = 1; v <= 4; v++) write_sample(12'(v));
    idle(2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", rd_valid, 1);
      check("t3_hold_data", rd_data, 1);
      check("t3_hold_last", rd_last, 0);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t3_nogap", rd_valid, 1);
      step();
    end
    check("t3_end_valid", rd_valid, 0);
    rd_ready = 1'b0;

    // T4: fill past full, sticky overflow, clear with/without a concurrent drop
    for (int v = 0; v < 9; v++) write_sample(12'(16 + v));
    check("t4_level", level, 8);
    check("t4_ovf", overflow, 1);
    din = 12'h0AA; din_valid = 1'b1; clr_ovf = 1'b1;
    step();
    din_valid = 1'b0;
    check("t4_ovf_clr_drop", overflow, 1);
    step();
    clr_ovf = 1'b0;
    check("t4_ovf_cleared", overflow, 0);
    drain(40);
    check("t4_drained", exp_q.size(), 0);
    check("t4_end_valid", rd_valid, 0);
    rd_ready = 1'b0;

    // T5: streaming writes overlapping bursts, pointers wrap several times
    rd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      din       = 12'((i * 37 + 5) & 12'hFFF);
      din_valid = (i % 3 != 2);
      step();
    end
    din_valid = 1'b0;
    drain(40);
    check("t5_tail_lt_frame", exp_q.size() < FRAME_LEN, 1);
    check("t5_end_valid", rd_valid, 0);
    check("t5_ovf", overflow, 0);
    rd_ready = 1'b0;
    apply_reset();

`ifdef FRAME_READER_PEAK_EN
    // T6: per-frame peak
    rd_ready = 1'b1;
    write_sample(12'd5);
    write_sample(12'hFFF);
    write_sample(12'd3);
    write_sample(12'd7);
    idle(7);
    check("t6_peak1", frame_peak, 12'hFFF);
    for (int i = 0; i < 4; i++) write_sample(12'd2);
    idle(7);
    check("t6_peak2", frame_peak, 12'd2);
    rd_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
